branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, giving the log2 of the pattern-table entry count (16 entries).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port id_pc  input  32  PC of the instruction in ID.
REQ-005 SHALL have port id_is_branch  input  1  ID instruction is a conditional branch (the datapath's branch_early).
REQ-006 SHALL have port id_is_jump  input  1  ID instruction is JAL/JALR and was redirected early (the datapath's jump_early).
REQ-007 SHALL have port stall  input  1  load-use stall; the EX slot receives a bubble.
REQ-008 SHALL have port flush  input  1  redirect; the EX and MEM slots are cleared.
REQ-009 SHALL have port branch_resolved  input  1  MEM-stage branch resolved (from datapath).
REQ-010 SHALL have port actual_taken  input  1  MEM-stage branch outcome (from datapath).
REQ-011 SHALL have port mispredict  input  1  MEM-stage misprediction (from datapath).
REQ-012 SHALL have port predict_taken  output  1  combinational ID-stage prediction for fetch redirect.
REQ-013 SHALL have port jump_taken  output  1  registered prediction of the MEM-stage instruction (to datapath).
REQ-014 SHALL have port branch_count  output  16  count of resolved branches.
REQ-015 SHALL have port mispredict_count  output  16  count of mispredicted branches.

Function
REQ-016 SHALL hold 2^IDX_BITS 2-bit saturating counters, indexed by id_pc[IDX_BITS+1:2].
REQ-017 SHALL drive predict_taken = id_is_jump | (id_is_branch & counter[idx][1]).
REQ-018 SHALL base predict_taken on the registered table value, with no bypass of an update made in the same cycle.
REQ-019 SHALL carry {valid, idx, pred} through two registered slots, ID->EX and EX->MEM, so that an ID-stage prediction appears on jump_taken exactly 2 cycles later.
REQ-020 SHALL set the valid bit of a slot only for branch or jump instructions; non-control instructions enter with valid=0.
REQ-021 SHALL drive jump_taken = mem_valid & mem_pred.
REQ-022 SHALL, on stall, load the EX slot with a bubble (valid=0) while MEM still advances from EX.
REQ-023 SHALL, on flush, clear both EX and MEM slots on the next edge.
REQ-024 SHALL give flush priority over stall.
REQ-025 SHALL, when branch_resolved & mem_valid, increment counter[mem_idx] if actual_taken and decrement it otherwise, saturating at 3 and 0.
REQ-026 SHALL ignore branch_resolved while mem_valid=0: no table update, no count.
REQ-027 SHALL increment branch_count on each accepted resolution, saturating at 16'hFFFF.
REQ-028 SHALL increment mispredict_count when an accepted resolution has mispredict=1, saturating at 16'hFFFF.
REQ-029 SHALL perform the table update even when flush is asserted in the same cycle, because the MEM instruction has already resolved.
REQ-030 SHALL NOT update the table or counters for jumps.

Reset
REQ-031 SHALL, on rst low, immediately set all counters to 2'b01 (weakly not-taken).
REQ-032 SHALL, on rst low, clear both slot valid bits and both stat counts; jump_taken reads 0 during and after reset.
REQ-033 SHALL abandon any in-flight prediction on reset mid-operation, with no update after rst deasserts.

Structure
REQ-034 SHALL place the counter encodings (SNT=0, WNT=1, WT=2, ST=3), the reset value and the stat width in the shared defines package alongside the STAGE_* constants.
REQ-035 SHALL implement the saturating 2-bit counter as the sub-module sat_counter2 (inputs inc/dec, output next value).

Verification
REQ-036 Reset, then id_pc=0x40 with id_is_branch=1 -> predict_taken=0, and jump_taken=0 two cycles later.
REQ-037 Resolve the branch at idx 0 as taken 3 times (mem_valid=1, actual_taken=1) -> counter=3, predict_taken=1, branch_count=3; a further taken resolution keeps the counter at 3.
REQ-038 Branch in ID with id_is_jump=1 -> jump_taken=1 exactly 2 cycles later; table unchanged.
REQ-039 Branch enters ID, then flush asserts the next cycle -> jump_taken=0 at MEM, and branch_resolved is ignored there (branch_count unchanged).
REQ-040 stall during a branch in ID -> bubble in EX, jump_taken=0 at the corresponding MEM cycle; a resolution with mispredict=1 afterwards -> mispredict_count increments by 1.
REQ-041 Update to idx 5 in the same cycle as an ID lookup of idx 5 -> predict_taken reflects the old value, and the new value is visible next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: pipeline stage numbering,
// 2-bit counter encodings, counter reset value and statistics width.
package branch_predictor_pkg;

  localparam int unsigned STAGE_ID  = 0;
  localparam int unsigned STAGE_EX  = STAGE_ID + 1;
  localparam int unsigned STAGE_MEM = STAGE_ID + 2;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned STAT_W   = 16;
  localparam int unsigned CTR_W    = 2;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

endpackage

// File: rtl/branch_predictor_if.sv
// Datapath <-> predictor bundle.
//   master: datapath side (drives ID/MEM info, receives predictions/stats)
//   slave : predictor side
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [PC_W-1:0]   id_pc;
  logic              id_is_branch;
  logic              id_is_jump;
  logic              stall;
  logic              flush;
  logic              branch_resolved;
  logic              actual_taken;
  logic              mispredict;
  logic              predict_taken;
  logic              jump_taken;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output id_pc, id_is_branch, id_is_jump, stall, flush,
           branch_resolved, actual_taken, mispredict,
    input  predict_taken, jump_taken, branch_count, mispredict_count
  );

  modport slave (
    input  id_pc, id_is_branch, id_is_jump, stall, flush,
           branch_resolved, actual_taken, mispredict,
    output predict_taken, jump_taken, branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating counter.
//   cur    : current counter value
//   inc    : step toward strongly taken (saturates at ST)
//   dec    : step toward strongly not-taken (saturates at SNT)
//   nxt_c  : combinational next value
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [CTR_W-1:0] cur,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] nxt_c
);

  always_comb begin
    nxt_c = cur;
    if (inc && !dec && (cur != CTR_W'(ST))) begin
      nxt_c = cur + CTR_W'(1);
    end else if (dec && !inc && (cur != CTR_W'(SNT))) begin
      nxt_c = cur - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit counters looked up in ID,
// the prediction carried through EX and MEM, and the table trained when
// the MEM-stage branch resolves.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bp   : predictor side of the datapath bundle
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  branch_predictor_if.slave bp
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [CTR_W-1:0]    ctr_q [ENTRIES];
  logic [CTR_W-1:0]    ctr_d [ENTRIES];
  logic [CTR_W-1:0]    ctr_nxt;

  // Slots indexed by stage number; upd marks a conditional branch
  // (jumps travel through the slots but never train the table).
  logic                slot_valid_q [STAGE_EX:STAGE_MEM];
  logic                slot_valid_d [STAGE_EX:STAGE_MEM];
  logic                slot_upd_q   [STAGE_EX:STAGE_MEM];
  logic                slot_upd_d   [STAGE_EX:STAGE_MEM];
  logic                slot_pred_q  [STAGE_EX:STAGE_MEM];
  logic                slot_pred_d  [STAGE_EX:STAGE_MEM];
  logic [IDX_BITS-1:0] slot_idx_q   [STAGE_EX:STAGE_MEM];
  logic [IDX_BITS-1:0] slot_idx_d   [STAGE_EX:STAGE_MEM];

  logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_BITS-1:0] id_idx;
  logic                accept;
  logic                unused_pc_bits;

  assign id_idx         = bp.id_pc[ADDR_LSB +: IDX_BITS];
  assign unused_pc_bits = ^{bp.id_pc[PC_W-1:ADDR_LSB+IDX_BITS], bp.id_pc[ADDR_LSB-1:0]};

  // ID lookup reads the registered table only; same-cycle updates show next cycle.
  assign bp.predict_taken = bp.id_is_jump | (bp.id_is_branch & ctr_q[id_idx][1]);

  assign accept = bp.branch_resolved & slot_valid_q[STAGE_MEM] & slot_upd_q[STAGE_MEM];

  sat_counter2 u_sat_counter2 (
    .cur   (ctr_q[slot_idx_q[STAGE_MEM]]),
    .inc   (accept & bp.actual_taken),
    .dec   (accept & ~bp.actual_taken),
    .nxt_c (ctr_nxt)
  );

  // Table update; flush does not block it since MEM has already resolved.
  always_comb begin
    ctr_d = ctr_q;
    if (accept) begin
      ctr_d[slot_idx_q[STAGE_MEM]] = ctr_nxt;
    end
  end

  // Slot advance: flush beats stall; stall bubbles EX while MEM still advances.
  always_comb begin
    slot_valid_d[STAGE_EX]  = bp.id_is_branch | bp.id_is_jump;
    slot_upd_d[STAGE_EX]    = bp.id_is_branch & ~bp.id_is_jump;
    slot_pred_d[STAGE_EX]   = bp.predict_taken;
    slot_idx_d[STAGE_EX]    = id_idx;
    slot_valid_d[STAGE_MEM] = slot_valid_q[STAGE_EX];
    slot_upd_d[STAGE_MEM]   = slot_upd_q[STAGE_EX];
    slot_pred_d[STAGE_MEM]  = slot_pred_q[STAGE_EX];
    slot_idx_d[STAGE_MEM]   = slot_idx_q[STAGE_EX];
    if (bp.flush) begin
      slot_valid_d[STAGE_EX]  = 1'b0;
      slot_valid_d[STAGE_MEM] = 1'b0;
    end else if (bp.stall) begin
      slot_valid_d[STAGE_EX]  = 1'b0;
    end
  end

  // Saturating statistics.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + STAT_W'(1);
    end
    if (accept && bp.mispredict && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_W'(CTR_RESET);
      end
      for (int unsigned s = STAGE_EX; s <= STAGE_MEM; s++) begin
        slot_valid_q[s] <= 1'b0;
        slot_upd_q[s]   <= 1'b0;
        slot_pred_q[s]  <= 1'b0;
        slot_idx_q[s]   <= '0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctr_q         <= ctr_d;
      slot_valid_q  <= slot_valid_d;
      slot_upd_q    <= slot_upd_d;
      slot_pred_q   <= slot_pred_d;
      slot_idx_q    <= slot_idx_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.jump_taken       = slot_valid_q[STAGE_MEM] & slot_pred_q[STAGE_MEM];
  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: per-cycle history model plus directed checks.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Model: per-cycle record of what ID saw; an ID entry reaches MEM two
  // cycles later unless stalled at issue, flushed in either of the two
  // cycles, or reset at any point in the window.
  localparam int MAXC = 1024;
  bit r_ctl [MAXC];
  bit r_upd [MAXC];
  bit r_stall [MAXC];
  bit r_flush [MAXC];
  bit r_rst [MAXC];
  bit r_pred [MAXC];
  int r_idx [MAXC];
  int m_ctr [16];
  int m_bc;
  int m_mc;
  int cyc = 0;

  always @(negedge clk) begin : model
    bit mv;
    bit ept;
    bit ejt;
    int ix;
    int j;
    if (cyc < MAXC) begin
      if (!rst) begin
        for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        m_bc = 0;
        m_mc = 0;
      end
      ix = int'(bp_if.id_pc[5:2]);
      ept = bp_if.id_is_jump || (bp_if.id_is_branch && (m_ctr[ix] >= 2));
      r_ctl[cyc]   = bp_if.id_is_branch || bp_if.id_is_jump;
      r_upd[cyc]   = bp_if.id_is_branch && !bp_if.id_is_jump;
      r_stall[cyc] = bp_if.stall;
      r_flush[cyc] = bp_if.flush;
      r_rst[cyc]   = !rst;
      r_idx[cyc]   = ix;
      r_pred[cyc]  = ept;
      mv = 1'b0;
      if (cyc >= 2) begin
        mv = r_ctl[cyc-2] && !r_stall[cyc-2] && !r_flush[cyc-2] && !r_flush[cyc-1]
             && !r_rst[cyc-2] && !r_rst[cyc-1] && !r_rst[cyc];
      end
      ejt = mv && r_pred[cyc-2 >= 0 ? cyc-2 : 0];
      chk("model_predict_taken", 32'(bp_if.predict_taken), 32'(ept));
      chk("model_jump_taken", 32'(bp_if.jump_taken), 32'(ejt));
      chk("model_branch_count", 32'(bp_if.branch_count), 32'(m_bc));
      chk("model_mispredict_count", 32'(bp_if.mispredict_count), 32'(m_mc));
      if (rst && bp_if.branch_resolved && mv && r_upd[cyc-2]) begin
        j = r_idx[cyc-2];
        if (bp_if.actual_taken) m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
        else                    m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
        if (m_bc < 65535) m_bc++;
        if (bp_if.mispredict && (m_mc < 65535)) m_mc++;
      end
      cyc++;
    end
  end

  // Apply inputs for the current cycle and move to its mid-point.
  task automatic drive(input logic [31:0] pc, input bit br, input bit jmp, input bit st,
                       input bit fl, input bit res, input bit act, input bit mis);
    bp_if.id_pc           = pc;
    bp_if.id_is_branch    = br;
    bp_if.id_is_jump      = jmp;
    bp_if.stall           = st;
    bp_if.flush           = fl;
    bp_if.branch_resolved = res;
    bp_if.actual_taken    = act;
    bp_if.mispredict      = mis;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Issue a branch, wait one cycle, resolve it in MEM.
  task automatic branch_round(input logic [31:0] pc, input bit act, input bit mis,
                              input bit fl_at_res, input bit exp_pred);
    drive(pc, 1, 0, 0, 0, 0, 0, 0);
    chk("round_predict", 32'(bp_if.predict_taken), 32'(exp_pred));
    tick();
    idle();
    drive(32'h0, 0, 0, 0, fl_at_res, 1, act, mis);
    chk("round_jump_taken", 32'(bp_if.jump_taken), 32'(exp_pred));
    tick();
  endtask

  initial begin
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_jump_taken", 32'(bp_if.jump_taken), 32'd0);
    chk("rst_branch_count", 32'(bp_if.branch_count), 32'd0);
    tick();
    idle();
    rst = 1'b1;

    // First lookup is weakly not-taken; train idx 0 to strongly taken.
    branch_round(32'h40, 1, 1, 0, 0);
    branch_round(32'h40, 1, 0, 0, 1);
    branch_round(32'h40, 1, 0, 0, 1);
    drive(32'h40, 1, 0, 0, 0, 0, 0, 0);
    chk("pred_after_3_taken", 32'(bp_if.predict_taken), 32'd1);
    chk("bc_after_3", 32'(bp_if.branch_count), 32'd3);
    chk("mc_after_3", 32'(bp_if.mispredict_count), 32'd1);
    tick();
    idle();
    idle();
    branch_round(32'h40, 1, 0, 0, 1);

    // Jump: predicted taken, reaches MEM, never trains or counts.
    drive(32'h44, 1, 1, 0, 0, 0, 0, 0);
    chk("jump_predict", 32'(bp_if.predict_taken), 32'd1);
    tick();
    idle();
    drive(32'h0, 0, 0, 0, 0, 1, 1, 0);
    chk("jump_at_mem", 32'(bp_if.jump_taken), 32'd1);
    tick();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("jump_bc_unchanged", 32'(bp_if.branch_count), 32'd4);
    tick();
    drive(32'h44, 1, 0, 0, 0, 0, 0, 0);
    chk("jump_table_unchanged", 32'(bp_if.predict_taken), 32'd0);
    tick();
    idle();
    idle();

    // Flush the cycle after issue: squashed, resolution ignored.
    drive(32'h48, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(32'h0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(32'h0, 0, 0, 0, 0, 1, 1, 1);
    chk("flush_jump_taken", 32'(bp_if.jump_taken), 32'd0);
    tick();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_bc", 32'(bp_if.branch_count), 32'd4);
    chk("flush_mc", 32'(bp_if.mispredict_count), 32'd1);
    tick();

    // Stall at issue: bubble; then a genuine mispredicted resolution.
    drive(32'h40, 1, 0, 1, 0, 0, 0, 0);
    chk("stall_predict", 32'(bp_if.predict_taken), 32'd1);
    tick();
    idle();
    drive(32'h0, 0, 0, 0, 0, 1, 0, 1);
    chk("stall_jump_taken", 32'(bp_if.jump_taken), 32'd0);
    tick();
    branch_round(32'h40, 0, 1, 0, 1);
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_mc", 32'(bp_if.mispredict_count), 32'd2);
    chk("stall_bc", 32'(bp_if.branch_count), 32'd5);
    tick();

    // Resolution concurrent with flush still trains idx 2.
    branch_round(32'h48, 1, 1, 1, 0);
    drive(32'h48, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_update_pred", 32'(bp_if.predict_taken), 32'd1);
    chk("flush_update_bc", 32'(bp_if.branch_count), 32'd6);
    tick();
    idle();
    idle();

    // Same-cycle update and lookup of idx 5: old value now, new value next.
    branch_round(32'h54, 1, 1, 0, 0);
    drive(32'h54, 1, 0, 0, 0, 0, 0, 0);
    chk("idx5_pred_wt", 32'(bp_if.predict_taken), 32'd1);
    tick();
    idle();
    drive(32'h54, 1, 0, 0, 0, 1, 0, 1);
    chk("idx5_old_value", 32'(bp_if.predict_taken), 32'd1);
    chk("idx5_jump_taken", 32'(bp_if.jump_taken), 32'd1);
    tick();
    drive(32'h54, 1, 0, 0, 0, 0, 0, 0);
    chk("idx5_new_value", 32'(bp_if.predict_taken), 32'd0);
    tick();
    idle();
    idle();

    // Saturation at 0 on idx 3.
    branch_round(32'h4C, 0, 0, 0, 0);
    branch_round(32'h4C, 0, 0, 0, 0);
    drive(32'h4C, 1, 0, 0, 0, 0, 0, 0);
    chk("sat0_pred", 32'(bp_if.predict_taken), 32'd0);
    chk("sat0_bc", 32'(bp_if.branch_count), 32'd10);
    tick();
    idle();
    idle();

    // Back-to-back branches with overlapping resolutions.
    drive(32'h40, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h40, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h40, 1, 0, 0, 0, 1, 1, 0); tick();
    drive(32'h0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(32'h0, 0, 0, 0, 0, 1, 0, 1); tick();
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_bc", 32'(bp_if.branch_count), 32'd13);
    tick();

    // Reset mid-flight abandons the in-flight branch.
    drive(32'h40, 1, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    chk("midrst_jump_taken", 32'(bp_if.jump_taken), 32'd0);
    tick();
    rst = 1'b1;
    drive(32'h0, 0, 0, 0, 0, 1, 1, 1);
    chk("postrst_jump_taken", 32'(bp_if.jump_taken), 32'd0);
    tick();
    drive(32'h40, 1, 0, 0, 0, 0, 0, 0);
    chk("postrst_bc", 32'(bp_if.branch_count), 32'd0);
    chk("postrst_mc", 32'(bp_if.mispredict_count), 32'd0);
    chk("postrst_pred", 32'(bp_if.predict_taken), 32'd0);
    tick();
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
